// File: rtl/alu_dispatch_pkg.sv
// Shared types and instruction field layout for the ALU dispatch block.
// ALU operation encoding, dispatch FSM states and field positions live here.
package alu_dispatch_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSA = 4'd10,
    ALU_PASSB = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_READ,
    DS_EXEC,
    DS_WB
  } dispatch_state_t;

  localparam int OP_HI       = 15;
  localparam int OP_LO       = 12;
  localparam int RD_HI       = 11;
  localparam int RD_LO       = 9;
  localparam int RS1_HI      = 8;
  localparam int RS1_LO      = 6;
  localparam int IMM_SEL_BIT = 5;
  localparam int IMM_HI      = 4;
  localparam int IMM_LO      = 0;
  localparam int RS2_HI      = 2;
  localparam int RS2_LO      = 0;

  localparam logic [3:0] ALU_OP_MAX = 4'd11;

  // Op codes above ALU_OP_MAX have no alu arm and must be rejected.
  function automatic logic isLegalOp(input logic [3:0] opRaw);
    return (opRaw <= ALU_OP_MAX);
  endfunction

endpackage

// File: rtl/alu_instr_decode.sv
// Combinational field splitter for 16-bit ALU instructions.
module alu_instr_decode
  import alu_dispatch_pkg::*;
(
  input  logic [15:0] instr_i,
  output alu_op_t     op_o,
  output logic [2:0]  rd_o,
  output logic [2:0]  rs1_o,
  output logic [2:0]  rs2_o,
  output logic [4:0]  imm_o,
  output logic        immSel_o,
  output logic        legal_o
);

  logic [3:0] opRaw;

  assign opRaw    = instr_i[OP_HI:OP_LO];
  assign op_o     = alu_op_t'(opRaw);
  assign rd_o     = instr_i[RD_HI:RD_LO];
  assign rs1_o    = instr_i[RS1_HI:RS1_LO];
  assign rs2_o    = instr_i[RS2_HI:RS2_LO];
  assign imm_o    = instr_i[IMM_HI:IMM_LO];
  assign immSel_o = instr_i[IMM_SEL_BIT];
  assign legal_o  = isLegalOp(opRaw);

endmodule

// File: rtl/alu_dispatch.sv
// ALU dispatch initiator: accept, read operands, execute, write back (4 cycles).
// Optional ALU_DISPATCH_FLAGS_EN adds registered zero/negative result flags.
module alu_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter int REG_W  = 16,
  parameter int OPND_W = 8,
  parameter int NREG   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    instr_valid,
  input  logic [15:0]             instr,
  output logic                    instr_ready,
  output logic [$clog2(NREG)-1:0] rf_raddr1,
  output logic [$clog2(NREG)-1:0] rf_raddr2,
  input  logic [REG_W-1:0]        rf_rdata1,
  input  logic [REG_W-1:0]        rf_rdata2,
  output logic                    rf_we,
  output logic [$clog2(NREG)-1:0] rf_waddr,
  output logic [REG_W-1:0]        rf_wdata,
  output alu_op_t                 alu_op,
  output logic [OPND_W-1:0]       alu_input1,
  output logic [OPND_W-1:0]       alu_input2,
  input  logic [REG_W-1:0]        alu_result,
  output logic                    done,
  output logic                    illegal
`ifdef ALU_DISPATCH_FLAGS_EN
  ,
  output logic                    flag_z,
  output logic                    flag_n
`endif
);

  localparam int AW = $clog2(NREG);

  alu_op_t    decOp;
  logic [2:0] decRd;
  logic [2:0] decRs1;
  logic [2:0] decRs2;
  logic [4:0] decImm;
  logic       decImmSel;
  logic       decLegal;

  alu_instr_decode uDecode (
    .instr_i  (instr),
    .op_o     (decOp),
    .rd_o     (decRd),
    .rs1_o    (decRs1),
    .rs2_o    (decRs2),
    .imm_o    (decImm),
    .immSel_o (decImmSel),
    .legal_o  (decLegal)
  );

  dispatch_state_t   state_q;
  logic              ready_q;
  alu_op_t           opLat_q;
  logic [AW-1:0]     rd_q;
  logic              immSel_q;
  logic [4:0]        imm_q;
  logic [AW-1:0]     raddr1_q;
  logic [AW-1:0]     raddr2_q;
  alu_op_t           aluOp_q;
  logic [OPND_W-1:0] op1_q;
  logic [OPND_W-1:0] op2_q;
  logic              rfWe_q;
  logic [AW-1:0]     waddr_q;
  logic [REG_W-1:0]  wdata_q;
  logic              done_q;
  logic              illegal_q;

  logic [OPND_W-1:0] op1_d;
  logic [OPND_W-1:0] op2_d;

  // Only the low OPND_W bits of each register feed the alu.
  logic unusedRdataHi;
  assign unusedRdataHi = ^{rf_rdata1[REG_W-1:OPND_W], rf_rdata2[REG_W-1:OPND_W]};

  always_comb begin
    op1_d = rf_rdata1[OPND_W-1:0];
    op2_d = rf_rdata2[OPND_W-1:0];
    if (immSel_q) begin
      op2_d = OPND_W'(imm_q);
    end
  end

`ifdef ALU_DISPATCH_FLAGS_EN
  logic flagZ_q;
  logic flagN_q;
`endif

  // Operands are captured in READ, so a writeback to rs1/rs2 cannot disturb them.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= DS_IDLE;
      ready_q   <= 1'b1;
      opLat_q   <= ALU_ADD;
      rd_q      <= '0;
      immSel_q  <= 1'b0;
      imm_q     <= '0;
      raddr1_q  <= '0;
      raddr2_q  <= '0;
      aluOp_q   <= ALU_ADD;
      op1_q     <= '0;
      op2_q     <= '0;
      rfWe_q    <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_DISPATCH_FLAGS_EN
      flagZ_q   <= 1'b0;
      flagN_q   <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      rfWe_q    <= 1'b0;
      unique case (state_q)
        DS_IDLE: begin
          if (instr_valid) begin
            if (decLegal) begin
              opLat_q  <= decOp;
              rd_q     <= AW'(decRd);
              immSel_q <= decImmSel;
              imm_q    <= decImm;
              raddr1_q <= AW'(decRs1);
              raddr2_q <= AW'(decRs2);
              ready_q  <= 1'b0;
              state_q  <= DS_READ;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        DS_READ: begin
          op1_q   <= op1_d;
          op2_q   <= op2_d;
          aluOp_q <= opLat_q;
          state_q <= DS_EXEC;
        end
        DS_EXEC: begin
          // alu_op drops back to ADD so the alu never decodes an undefined arm.
          aluOp_q <= ALU_ADD;
          wdata_q <= alu_result;
          waddr_q <= rd_q;
          rfWe_q  <= (rd_q != '0);
          done_q  <= 1'b1;
`ifdef ALU_DISPATCH_FLAGS_EN
          flagZ_q <= (alu_result == '0);
          flagN_q <= alu_result[REG_W-1];
`endif
          state_q <= DS_WB;
        end
        DS_WB: begin
          ready_q <= 1'b1;
          state_q <= DS_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= DS_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign rf_raddr1   = raddr1_q;
  assign rf_raddr2   = raddr2_q;
  assign rf_we       = rfWe_q;
  assign rf_waddr    = waddr_q;
  assign rf_wdata    = wdata_q;
  assign alu_op      = aluOp_q;
  assign alu_input1  = op1_q;
  assign alu_input2  = op2_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
`ifdef ALU_DISPATCH_FLAGS_EN
  assign flag_z      = flagZ_q;
  assign flag_n      = flagN_q;
`endif

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a behavioural register file and alu.
// Flag checks are compiled in when ALU_DISPATCH_FLAGS_EN is defined.
module tb_alu_dispatch;
  import alu_dispatch_pkg::*;

  logic        clock;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [2:0]  rf_raddr1;
  logic [2:0]  rf_raddr2;
  logic [15:0] rf_rdata1;
  logic [15:0] rf_rdata2;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  alu_op_t     alu_op;
  logic [7:0]  alu_input1;
  logic [7:0]  alu_input2;
  logic [15:0] alu_result;
  logic        done;
  logic        illegal;
`ifdef ALU_DISPATCH_FLAGS_EN
  logic        flag_z;
  logic        flag_n;
`endif

  int checkCount = 0;
  int errorCount = 0;

  logic [15:0] regs [8];
  logic        preWe;
  logic [2:0]  preAddr;
  logic [15:0] preData;

  alu_dispatch #(.REG_W(16), .OPND_W(8), .NREG(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .rf_raddr1   (rf_raddr1),
    .rf_raddr2   (rf_raddr2),
    .rf_rdata1   (rf_rdata1),
    .rf_rdata2   (rf_rdata2),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .alu_op      (alu_op),
    .alu_input1  (alu_input1),
    .alu_input2  (alu_input2),
    .alu_result  (alu_result),
    .done        (done),
    .illegal     (illegal)
`ifdef ALU_DISPATCH_FLAGS_EN
    ,
    .flag_z      (flag_z),
    .flag_n      (flag_n)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file: combinational read, write on posedge; preload port has priority.
  always @(posedge clock) begin
    if (preWe) regs[preAddr] <= preData;
    else if (rf_we) regs[rf_waddr] <= rf_wdata;
  end
  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  // Reference alu; SLL/SRL/SRA use the low 4 bits of operand 2 as the shift amount.
  always_comb begin
    alu_result = 'x;
    case (alu_op)
      ALU_ADD:   alu_result = 16'(alu_input1) + 16'(alu_input2);
      ALU_SUB:   alu_result = 16'(alu_input1) - 16'(alu_input2);
      ALU_AND:   alu_result = 16'(alu_input1 & alu_input2);
      ALU_OR:    alu_result = 16'(alu_input1 | alu_input2);
      ALU_XOR:   alu_result = 16'(alu_input1 ^ alu_input2);
      ALU_SLL:   alu_result = 16'(alu_input1) << alu_input2[3:0];
      ALU_SRL:   alu_result = 16'(alu_input1) >> alu_input2[3:0];
      ALU_SRA:   alu_result = $signed({{8{alu_input1[7]}}, alu_input1}) >>> alu_input2[3:0];
      ALU_SLT:   alu_result = {15'd0, ($signed(alu_input1) < $signed(alu_input2))};
      ALU_SLTU:  alu_result = {15'd0, (alu_input1 < alu_input2)};
      ALU_PASSA: alu_result = 16'(alu_input1);
      ALU_PASSB: alu_result = 16'(alu_input2);
      default:   alu_result = 'x;
    endcase
  end

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic immSel,
                                     input logic [4:0] lo);
    return {op, rd, rs1, immSel, lo};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic setReg(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clock);
    preWe   = 1'b1;
    preAddr = addr;
    preData = data;
    @(negedge clock);
    preWe   = 1'b0;
  endtask

  // Issues one instruction from IDLE and checks cycles 0..4 of its life.
  task automatic applyStimulus(input string tag, input logic [15:0] word,
                               input logic [2:0] expRa1, input logic [3:0] expOp,
                               input logic [7:0] expIn1, input logic [7:0] expIn2,
                               input logic expWe, input logic [2:0] expWaddr,
                               input logic [15:0] expWdata);
    @(negedge clock);
    instr       = word;
    instr_valid = 1'b1;
    checkOutput({tag, "_ready_c0"}, 32'(instr_ready), 32'd1);
    @(negedge clock);
    instr_valid = 1'b0;
    checkOutput({tag, "_ready_c1"}, 32'(instr_ready), 32'd0);
    checkOutput({tag, "_raddr1"}, 32'(rf_raddr1), 32'(expRa1));
    @(negedge clock);
    checkOutput({tag, "_aluop"}, 32'(alu_op), 32'(expOp));
    checkOutput({tag, "_in1"}, 32'(alu_input1), 32'(expIn1));
    checkOutput({tag, "_in2"}, 32'(alu_input2), 32'(expIn2));
    checkOutput({tag, "_we_c2"}, 32'(rf_we), 32'd0);
    @(negedge clock);
    checkOutput({tag, "_we"}, 32'(rf_we), 32'(expWe));
    checkOutput({tag, "_waddr"}, 32'(rf_waddr), 32'(expWaddr));
    checkOutput({tag, "_wdata"}, 32'(rf_wdata), 32'(expWdata));
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_aluop_wb"}, 32'(alu_op), 32'(ALU_ADD));
    @(negedge clock);
    checkOutput({tag, "_ready_c4"}, 32'(instr_ready), 32'd1);
    checkOutput({tag, "_done_c4"}, 32'(done), 32'd0);
    checkOutput({tag, "_we_c4"}, 32'(rf_we), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"}, 32'(instr_ready), 32'd1);
    checkOutput({tag, "_we"}, 32'(rf_we), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_illegal"}, 32'(illegal), 32'd0);
    checkOutput({tag, "_aluop"}, 32'(alu_op), 32'(ALU_ADD));
    checkOutput({tag, "_in1"}, 32'(alu_input1), 32'd0);
    checkOutput({tag, "_in2"}, 32'(alu_input2), 32'd0);
    checkOutput({tag, "_raddr1"}, 32'(rf_raddr1), 32'd0);
    checkOutput({tag, "_raddr2"}, 32'(rf_raddr2), 32'd0);
    checkOutput({tag, "_waddr"}, 32'(rf_waddr), 32'd0);
    checkOutput({tag, "_wdata"}, 32'(rf_wdata), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [15:0] bbInstr [3];
  logic [2:0]  bbAddr  [3];
  logic [15:0] bbData  [3];

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    preWe       = 1'b0;
    preAddr     = 3'd0;
    preData     = 16'h0000;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checkResetOutputs("rst");
    for (int i = 0; i < 8; i++) setReg(3'(i), 16'h0000);

    // Basic ADD: 5 + 7 -> r3.
    setReg(3'd1, 16'd5);
    setReg(3'd2, 16'd7);
    applyStimulus("add", mk(4'd0, 3'd3, 3'd1, 1'b0, 5'd2), 3'd1, 4'd0, 8'd5, 8'd7,
                  1'b1, 3'd3, 16'd12);
    checkOutput("add_rf_r3", 32'(regs[3]), 32'd12);

    // SUB wraps without saturation; SLTU and SLT compares.
    setReg(3'd1, 16'd3);
    setReg(3'd2, 16'd5);
    applyStimulus("sub", mk(4'd1, 3'd4, 3'd1, 1'b0, 5'd2), 3'd1, 4'd1, 8'd3, 8'd5,
                  1'b1, 3'd4, 16'hFFFE);
`ifdef ALU_DISPATCH_FLAGS_EN
    checkOutput("sub_flag_z", 32'(flag_z), 32'd0);
    checkOutput("sub_flag_n", 32'(flag_n), 32'd1);
`endif
    applyStimulus("sltu", mk(4'd9, 3'd4, 3'd1, 1'b0, 5'd2), 3'd1, 4'd9, 8'd3, 8'd5,
                  1'b1, 3'd4, 16'd1);
    setReg(3'd1, 16'h0080);
    setReg(3'd2, 16'd1);
    applyStimulus("slt", mk(4'd8, 3'd5, 3'd1, 1'b0, 5'd2), 3'd1, 4'd8, 8'h80, 8'd1,
                  1'b1, 3'd5, 16'd1);

    // Immediate operand and r0 destination.
    setReg(3'd1, 16'd1);
    applyStimulus("sll_imm", mk(4'd5, 3'd2, 3'd1, 1'b1, 5'd31), 3'd1, 4'd5, 8'd1, 8'd31,
                  1'b1, 3'd2, 16'h8000);
    applyStimulus("add_r0", mk(4'd0, 3'd0, 3'd1, 1'b0, 5'd2), 3'd1, 4'd0, 8'd1, 8'd0,
                  1'b0, 3'd0, 16'd1);
    checkOutput("add_r0_rf", 32'(regs[0]), 32'd0);

    // Illegal op, then a normal instruction.
    @(negedge clock);
    instr       = mk(4'hD, 3'd6, 3'd1, 1'b0, 5'd2);
    instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    checkOutput("ill_pulse", 32'(illegal), 32'd1);
    checkOutput("ill_we", 32'(rf_we), 32'd0);
    checkOutput("ill_done", 32'(done), 32'd0);
    checkOutput("ill_ready", 32'(instr_ready), 32'd1);
    @(negedge clock);
    checkOutput("ill_pulse_end", 32'(illegal), 32'd0);
    checkOutput("ill_we_after", 32'(rf_we), 32'd0);
    applyStimulus("post_ill", mk(4'd0, 3'd6, 3'd1, 1'b1, 5'd4), 3'd1, 4'd0, 8'd1, 8'd4,
                  1'b1, 3'd6, 16'd5);

    // Reset while in EXEC aborts the instruction.
    @(negedge clock);
    instr       = mk(4'd1, 3'd7, 3'd1, 1'b0, 5'd2);
    instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    @(negedge clock);
    checkOutput("rexec_aluop", 32'(alu_op), 32'(ALU_SUB));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkResetOutputs("rexec");
    @(negedge clock);
    checkOutput("rexec_we_next", 32'(rf_we), 32'd0);
    checkOutput("rexec_done_next", 32'(done), 32'd0);
    @(negedge clock);
    checkOutput("rexec_rf_r7", 32'(regs[7]), 32'd0);

    // Back-to-back with instr_valid held high; results chain through r1 and r2.
    bbInstr[0] = mk(4'd0, 3'd1, 3'd6, 1'b0, 5'd4);
    bbInstr[1] = mk(4'd1, 3'd2, 3'd1, 1'b0, 5'd5);
    bbInstr[2] = mk(4'd4, 3'd3, 3'd2, 1'b0, 5'd1);
    bbAddr[0] = 3'd1; bbData[0] = 16'd6;
    bbAddr[1] = 3'd2; bbData[1] = 16'd5;
    bbAddr[2] = 3'd3; bbData[2] = 16'd3;
    @(negedge clock);
    instr_valid = 1'b1;
    instr       = bbInstr[0];
    checkOutput("bb_ready_start", 32'(instr_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (k < 2) instr = bbInstr[k+1];
      else instr_valid = 1'b0;
      checkOutput("bb_ready_busy", 32'(instr_ready), 32'd0);
      @(negedge clock);
      @(negedge clock);
      checkOutput("bb_we", 32'(rf_we), 32'd1);
      checkOutput("bb_waddr", 32'(rf_waddr), 32'(bbAddr[k]));
      checkOutput("bb_wdata", 32'(rf_wdata), 32'(bbData[k]));
      @(negedge clock);
      checkOutput("bb_ready_c4", 32'(instr_ready), 32'd1);
    end
    checkOutput("bb_rf_r3", 32'(regs[3]), 32'd3);

    // Zero result to r0: no write, zero flag set where present.
    applyStimulus("sub_zero", mk(4'd1, 3'd0, 3'd5, 1'b0, 5'd5), 3'd5, 4'd1, 8'd1, 8'd1,
                  1'b0, 3'd0, 16'd0);
`ifdef ALU_DISPATCH_FLAGS_EN
    checkOutput("zero_flag_z", 32'(flag_z), 32'd1);
    checkOutput("zero_flag_n", 32'(flag_n), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
